// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer slice.
//   SIZE_DEFAULT / PS_W_DEFAULT : default count and prescaler widths
//   state_t                     : run-control state encoding (IDLE=0, RUN=1, HOLD=2, DONE=3)
//   is_busy()                   : true while a count is in progress (RUN or HOLD)
package counter_sequencer_pkg;

  localparam int SIZE_DEFAULT = 8;
  localparam int PS_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == ST_RUN) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/counter_sequencer_if.sv
// Control/status bundle between user controls and the counter sequencer.
//   start, stop, pause, auto_rld : run-control levels from buttons/registers
//   limit                        : terminal count (SIZE bits), latched on start
//   prescale                     : divide ratio minus one (PS_W bits), latched on start
//   count, tick, busy, done      : counter status back to displays/downstream logic
//   state                        : raw 2-bit state encoding
// master drives the controls; slave is the sequencer itself.
interface counter_sequencer_if
  import counter_sequencer_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT,
  parameter int PS_W = PS_W_DEFAULT
);

  logic            start;
  logic            stop;
  logic            pause;
  logic            auto_rld;
  logic [SIZE-1:0] limit;
  logic [PS_W-1:0] prescale;
  logic [SIZE-1:0] count;
  logic            tick;
  logic            busy;
  logic            done;
  logic [1:0]      state;

  modport master (
    output start, stop, pause, auto_rld, limit, prescale,
    input  count, tick, busy, done, state
  );

  modport slave (
    input  start, stop, pause, auto_rld, limit, prescale,
    output count, tick, busy, done, state
  );

endinterface

// File: rtl/counter_sequencer_prescaler_en.sv
// Clock-enable generator for the counter: produces a one-cycle en every div+1
// active cycles.
//   clk  : board clock
//   rst  : synchronous active-high reset
//   clr  : restart the divide phase from zero (used on start/stop)
//   hold : freeze the phase and suppress en (paused or not running)
//   div  : divide ratio minus one
//   en   : enable pulse, combinational from the current phase
module prescaler_en #(
  parameter int PS_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            hold,
  input  logic [PS_W-1:0] div,
  output logic            en
);

  logic [PS_W-1:0] psc_q;

  assign en = !hold && (psc_q == div);

  // Phase counter: clr beats hold so a restart always begins a fresh period,
  // while hold keeps the phase so a resumed run finishes the interrupted one.
  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q <= '0;
    end else if (clr) begin
      psc_q <= '0;
    end else if (!hold) begin
      if (en) begin
        psc_q <= '0;
      end else begin
        psc_q <= psc_q + PS_W'(1);
      end
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Run-control for the board's up-counter: start/stop/pause, programmable
// terminal count, prescaled increments, one-shot or auto-reload, and a
// one-cycle tick when the count leaves its terminal value.
//   clk : board clock
//   rst : synchronous active-high reset
//   bus : slave side of counter_sequencer_if (controls in, status out)
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT,
  parameter int PS_W = PS_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  counter_sequencer_if.slave bus
);

  state_t          state_q, state_d;
  logic [SIZE-1:0] count_q, count_d;
  logic [SIZE-1:0] limit_q;
  logic [PS_W-1:0] prescale_q;
  logic            auto_q;
  logic            tick_q, tick_d;
  logic            load_cfg;
  logic            psc_clr;
  logic            psc_hold;
  logic            en;
  logic            at_limit;

  // The prescaler only advances in RUN on an edge that is neither paused nor
  // stopped, so a pause or stop edge never produces an increment.
  assign psc_hold = (state_q != ST_RUN) || bus.pause || bus.stop;
  assign at_limit = (count_q == limit_q);

  prescaler_en #(.PS_W(PS_W)) u_psc (
    .clk  (clk),
    .rst  (rst),
    .clr  (psc_clr),
    .hold (psc_hold),
    .div  (prescale_q),
    .en   (en)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control. Stop is checked first so it overrides a
  // terminal count on the same edge; pause is checked before en in RUN.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    tick_d   = 1'b0;
    load_cfg = 1'b0;
    psc_clr  = 1'b0;
    if (bus.stop) begin
      state_d = ST_IDLE;
      count_d = '0;
      psc_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            load_cfg = 1'b1;
            count_d  = '0;
            psc_clr  = 1'b1;
            state_d  = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.pause) begin
            state_d = ST_HOLD;
          end else if (en) begin
            if (at_limit) begin
              tick_d = 1'b1;
              if (auto_q) begin
                count_d = '0;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              count_d = count_q + SIZE'(1);
            end
          end
        end
        ST_HOLD: begin
          if (!bus.pause) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Count, tick and configuration latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      tick_q     <= 1'b0;
      limit_q    <= '0;
      prescale_q <= '0;
      auto_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      if (load_cfg) begin
        limit_q    <= bus.limit;
        prescale_q <= bus.prescale;
        auto_q     <= bus.auto_rld;
      end
    end
  end

  assign bus.count = count_q;
  assign bus.tick  = tick_q;
  assign bus.busy  = is_busy(state_q);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.state = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed self-checking bench for counter_sequencer. Inputs change 1 time
// unit after each rising edge and outputs are sampled at that same point.
module tb_counter_sequencer;
  import counter_sequencer_pkg::*;

  localparam int SIZE = 8;
  localparam int PS_W = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  counter_sequencer_if #(.SIZE(SIZE), .PS_W(PS_W)) bus ();

  counter_sequencer #(.SIZE(SIZE), .PS_W(PS_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic applyStimulus(input logic s, input logic sp, input logic p, input logic a,
                               input logic [SIZE-1:0] lim, input logic [PS_W-1:0] ps);
    bus.start    = s;
    bus.stop     = sp;
    bus.pause    = p;
    bus.auto_rld = a;
    bus.limit    = lim;
    bus.prescale = ps;
  endtask

  task automatic stepClock(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [SIZE-1:0] cnt, input logic tk,
                          input state_t st);
    checkOutput({tag, ".count"}, 32'(bus.count), 32'(cnt));
    checkOutput({tag, ".tick"},  32'(bus.tick),  32'(tk));
    checkOutput({tag, ".state"}, 32'(bus.state), 32'(st));
    checkOutput({tag, ".busy"},  32'(bus.busy),  32'((st == ST_RUN) || (st == ST_HOLD)));
    checkOutput({tag, ".done"},  32'(bus.done),  32'(st == ST_DONE));
  endtask

  initial begin
    // Reset with start held: nothing may be accepted on the reset edges.
    rst = 1'b1;
    applyStimulus(1, 0, 0, 0, 8'd9, 16'd0);
    stepClock(2);
    checkAll("reset", 8'd0, 1'b0, ST_IDLE);
    rst = 1'b0;
    applyStimulus(0, 0, 1, 0, 8'd9, 16'd0);
    stepClock(1);
    checkAll("idle_pause", 8'd0, 1'b0, ST_IDLE);

    // One-shot, limit=3, prescale=0.
    $display("[TB] one-shot limit=3");
    applyStimulus(1, 0, 0, 0, 8'd3, 16'd0);
    stepClock(1);
    checkAll("os_start", 8'd0, 1'b0, ST_RUN);
    applyStimulus(0, 0, 0, 0, 8'd7, 16'd5);
    stepClock(1);
    checkAll("os_c1", 8'd1, 1'b0, ST_RUN);
    stepClock(1);
    checkAll("os_c2", 8'd2, 1'b0, ST_RUN);
    stepClock(1);
    checkAll("os_c3", 8'd3, 1'b0, ST_RUN);
    stepClock(1);
    checkAll("os_tick", 8'd3, 1'b1, ST_DONE);
    stepClock(1);
    checkAll("os_after", 8'd3, 1'b0, ST_DONE);
    stepClock(10);
    checkAll("os_hold10", 8'd3, 1'b0, ST_DONE);
    applyStimulus(0, 0, 1, 0, 8'd7, 16'd5);
    stepClock(1);
    checkAll("done_pause", 8'd3, 1'b0, ST_DONE);

    // Auto-reload, limit=2, prescale=2: increments every 3 cycles, tick every 9.
    $display("[TB] auto-reload limit=2 prescale=2");
    applyStimulus(1, 0, 0, 1, 8'd2, 16'd2);
    stepClock(1);
    checkAll("ar_start", 8'd0, 1'b0, ST_RUN);
    applyStimulus(0, 0, 0, 1, 8'd2, 16'd2);
    stepClock(2);
    checkAll("ar_n2", 8'd0, 1'b0, ST_RUN);
    stepClock(1);
    checkAll("ar_n3", 8'd1, 1'b0, ST_RUN);
    stepClock(3);
    checkAll("ar_n6", 8'd2, 1'b0, ST_RUN);
    stepClock(3);
    checkAll("ar_n9", 8'd0, 1'b1, ST_RUN);
    stepClock(1);
    checkAll("ar_n10", 8'd0, 1'b0, ST_RUN);
    stepClock(2);
    checkAll("ar_n12", 8'd1, 1'b0, ST_RUN);
    stepClock(6);
    checkAll("ar_n18", 8'd0, 1'b1, ST_RUN);
    applyStimulus(0, 1, 0, 1, 8'd2, 16'd2);
    stepClock(1);
    checkAll("ar_stop", 8'd0, 1'b0, ST_IDLE);

    // Pause for 5 cycles mid-run, limit=10, prescale=1.
    $display("[TB] pause limit=10 prescale=1");
    applyStimulus(1, 0, 0, 0, 8'd10, 16'd1);
    stepClock(1);
    applyStimulus(0, 0, 0, 0, 8'd10, 16'd1);
    stepClock(5);
    checkAll("ps_n5", 8'd2, 1'b0, ST_RUN);
    applyStimulus(0, 0, 1, 0, 8'd10, 16'd1);
    stepClock(1);
    checkAll("ps_hold1", 8'd2, 1'b0, ST_HOLD);
    stepClock(4);
    checkAll("ps_hold5", 8'd2, 1'b0, ST_HOLD);
    applyStimulus(1, 0, 0, 0, 8'd10, 16'd1);
    stepClock(1);
    checkAll("ps_resume", 8'd2, 1'b0, ST_RUN);
    applyStimulus(0, 0, 0, 0, 8'd10, 16'd1);
    stepClock(1);
    checkAll("ps_phase", 8'd3, 1'b0, ST_RUN);
    stepClock(2);
    checkAll("ps_next", 8'd4, 1'b0, ST_RUN);
    applyStimulus(0, 1, 0, 0, 8'd10, 16'd1);
    stepClock(1);
    checkAll("ps_stop", 8'd0, 1'b0, ST_IDLE);

    // Stop on the same edge as the terminal en, limit=1.
    $display("[TB] stop vs terminal count");
    applyStimulus(1, 0, 0, 0, 8'd1, 16'd0);
    stepClock(1);
    applyStimulus(0, 0, 0, 0, 8'd1, 16'd0);
    stepClock(1);
    checkAll("st_c1", 8'd1, 1'b0, ST_RUN);
    applyStimulus(0, 1, 0, 0, 8'd1, 16'd0);
    stepClock(1);
    checkAll("st_stop", 8'd0, 1'b0, ST_IDLE);
    applyStimulus(0, 0, 0, 0, 8'd1, 16'd0);
    stepClock(1);
    checkAll("st_after", 8'd0, 1'b0, ST_IDLE);

    // Start during RUN is ignored; restart from DONE with limit=0.
    $display("[TB] start in RUN and DONE");
    applyStimulus(1, 0, 0, 0, 8'd2, 16'd0);
    stepClock(1);
    applyStimulus(1, 0, 0, 0, 8'd5, 16'd0);
    stepClock(1);
    checkAll("rs_c1", 8'd1, 1'b0, ST_RUN);
    stepClock(1);
    checkAll("rs_c2", 8'd2, 1'b0, ST_RUN);
    applyStimulus(0, 0, 0, 0, 8'd0, 16'd0);
    stepClock(1);
    checkAll("rs_tick", 8'd2, 1'b1, ST_DONE);
    applyStimulus(1, 0, 0, 0, 8'd0, 16'd0);
    stepClock(1);
    checkAll("l0_start", 8'd0, 1'b0, ST_RUN);
    applyStimulus(0, 0, 0, 0, 8'd0, 16'd0);
    stepClock(1);
    checkAll("l0_tick", 8'd0, 1'b1, ST_DONE);
    stepClock(1);
    checkAll("l0_after", 8'd0, 1'b0, ST_DONE);

    // Full-range auto-reload wrap at 255.
    $display("[TB] full-range wrap");
    applyStimulus(1, 0, 0, 1, 8'd255, 16'd0);
    stepClock(1);
    applyStimulus(0, 0, 0, 1, 8'd255, 16'd0);
    stepClock(255);
    checkAll("fr_255", 8'd255, 1'b0, ST_RUN);
    stepClock(1);
    checkAll("fr_wrap", 8'd0, 1'b1, ST_RUN);
    stepClock(1);
    checkAll("fr_one", 8'd1, 1'b0, ST_RUN);

    // Reset mid-run beats start/pause.
    rst = 1'b1;
    applyStimulus(1, 0, 1, 1, 8'd255, 16'd0);
    stepClock(1);
    checkAll("rst_run", 8'd0, 1'b0, ST_IDLE);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 8'd0, 16'd0);
    stepClock(1);
    checkAll("rst_after", 8'd0, 1'b0, ST_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
